// File: rtl/core_round_seq_pkg.sv
// rtl/core_round_seq_pkg.sv - shared timing constants and state encoding for the round sequencer
package core_round_seq_pkg;

  // Job shape: 8 word-pair load cycles followed by the 64 SHA-256 rounds
  localparam int LOAD_CYCLES = 8;
  localparam int N_ROUNDS    = 64;
  localparam int PHASE_W     = 7;

  // The phase counter runs 0..71 across one whole job
  localparam logic [PHASE_W-1:0] LAST_LOAD  = PHASE_W'(LOAD_CYCLES - 1);
  localparam logic [PHASE_W-1:0] LAST_ROUND = PHASE_W'(LOAD_CYCLES + N_ROUNDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_ROUND = 2'd2
  } state_t;

endpackage

// File: rtl/core_round_seq.sv
// rtl/core_round_seq.sv - per-core slot sequencer: load 8 word pairs then run 64 rounds, alternating threads
module core_round_seq #(
  parameter logic THREAD_INIT = 1'b0
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       start,
  input  logic [1:0] thread_rdy,
  output logic       load_en,
  output logic [2:0] load_addr,
  output logic       round_en,
  output logic [5:0] round_idx,
  output logic       cur_thread,
  output logic       done,
  output logic       done_thread,
  output logic       skipped,
  output logic       busy,
  output logic       overrun
);
  import core_round_seq_pkg::*;

  state_t               r_state;
  logic [PHASE_W-1:0]   r_phase;
  logic                 r_ptr;
  logic                 r_cur_thread;
  logic                 r_done;
  logic                 r_done_thread;
  logic                 r_skipped;
  logic                 r_overrun;

  state_t               w_state_nx;
  logic [PHASE_W-1:0]   w_phase_nx;
  logic                 w_ptr_nx;
  logic                 w_cur_thread_nx;
  logic                 w_done_nx;
  logic                 w_done_thread_nx;
  logic                 w_skipped_nx;
  logic                 w_overrun_nx;

  logic                 w_last_round;
  logic                 w_accept;
  logic                 w_run;
  logic [5:0]           w_round_off;

  // A slot is only takeable when idle or on the very last round of the current job
  assign w_last_round = (r_state == ST_ROUND) && (r_phase == LAST_ROUND);
  assign w_accept     = start && ((r_state == ST_IDLE) || w_last_round);
  assign w_run        = w_accept && thread_rdy[r_ptr];

  // Next-state and next-register values; the shared phase counter spans load and rounds
  always_comb begin
    w_state_nx       = r_state;
    w_phase_nx       = r_phase;
    w_ptr_nx         = r_ptr;
    w_cur_thread_nx  = r_cur_thread;
    w_done_nx        = 1'b0;
    w_done_thread_nx = 1'b0;
    w_skipped_nx     = 1'b0;
    w_overrun_nx     = r_overrun | (start && !w_accept);

    case (r_state)
      ST_LOAD: begin
        w_phase_nx = r_phase + 1'b1;
        if (r_phase == LAST_LOAD) begin
          w_state_nx = ST_ROUND;
        end
      end
      ST_ROUND: begin
        if (w_last_round) begin
          w_done_nx        = 1'b1;
          w_done_thread_nx = r_cur_thread;
          w_state_nx       = ST_IDLE;
          w_phase_nx       = '0;
        end else begin
          w_phase_nx = r_phase + 1'b1;
        end
      end
      default: begin
        w_phase_nx = '0;
      end
    endcase

    // An accepted slot always advances the thread pointer, even when skipped
    if (w_accept) begin
      w_ptr_nx = ~r_ptr;
      if (w_run) begin
        w_cur_thread_nx = r_ptr;
        w_state_nx      = ST_LOAD;
        w_phase_nx      = '0;
      end else begin
        w_skipped_nx = 1'b1;
      end
    end
  end

  // State register; reset abandons any job without a done pulse
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state       <= ST_IDLE;
      r_phase       <= '0;
      r_ptr         <= THREAD_INIT;
      r_cur_thread  <= THREAD_INIT;
      r_done        <= 1'b0;
      r_done_thread <= 1'b0;
      r_skipped     <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      r_state       <= w_state_nx;
      r_phase       <= w_phase_nx;
      r_ptr         <= w_ptr_nx;
      r_cur_thread  <= w_cur_thread_nx;
      r_done        <= w_done_nx;
      r_done_thread <= w_done_thread_nx;
      r_skipped     <= w_skipped_nx;
      r_overrun     <= w_overrun_nx;
    end
  end

  // Outputs decode registered state only; indices read zero while their enable is low
  assign w_round_off = r_phase[5:0] - 6'(LOAD_CYCLES);
  assign load_en     = (r_state == ST_LOAD);
  assign load_addr   = load_en ? r_phase[2:0] : 3'd0;
  assign round_en    = (r_state == ST_ROUND);
  assign round_idx   = round_en ? w_round_off : 6'd0;
  assign busy        = (r_state != ST_IDLE);
  assign cur_thread  = r_cur_thread;
  assign done        = r_done;
  assign done_thread = r_done_thread;
  assign skipped     = r_skipped;
  assign overrun     = r_overrun;

endmodule

// File: tb/tb_core_round_seq.sv
// tb/tb_core_round_seq.sv - self-checking bench for core_round_seq
module tb_core_round_seq;

  logic       CLK = 1'b0;
  logic       RESET_N;
  logic       start;
  logic [1:0] thread_rdy;
  logic       load_en;
  logic [2:0] load_addr;
  logic       round_en;
  logic [5:0] round_idx;
  logic       cur_thread;
  logic       done;
  logic       done_thread;
  logic       skipped;
  logic       busy;
  logic       overrun;

  core_round_seq #(.THREAD_INIT(1'b0)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .start(start), .thread_rdy(thread_rdy),
    .load_en(load_en), .load_addr(load_addr), .round_en(round_en), .round_idx(round_idx),
    .cur_thread(cur_thread), .done(done), .done_thread(done_thread), .skipped(skipped),
    .busy(busy), .overrun(overrun)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int   cyc;
    logic thr;
  } ev_t;

  ev_t  done_q[$];
  int   skip_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  logic exp_ptr  = 1'b0;
  logic exp_ovr  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step();
    ev_t e;
    @(posedge CLK);
    #1;
    cyc++;
    if (done === 1'b1) begin
      if (done_q.size() == 0) begin
        chk("done_unexpected", 32'(done), 32'd0);
      end else begin
        e = done_q.pop_front();
        chk("done_cycle", 32'(cyc), 32'(e.cyc));
        chk("done_thread", 32'(done_thread), 32'(e.thr));
      end
    end else if (done_q.size() != 0 && done_q[0].cyc <= cyc) begin
      chk("done_missing", 32'(done), 32'd1);
      void'(done_q.pop_front());
    end
    if (skipped === 1'b1) begin
      if (skip_q.size() == 0) begin
        chk("skip_unexpected", 32'(skipped), 32'd0);
      end else begin
        chk("skip_cycle", 32'(cyc), 32'(skip_q.pop_front()));
      end
    end else if (skip_q.size() != 0 && skip_q[0] <= cyc) begin
      chk("skip_missing", 32'(skipped), 32'd1);
      void'(skip_q.pop_front());
    end
    if (load_en !== 1'b1 && load_addr !== 3'd0) chk("load_addr_idle", 32'(load_addr), 32'd0);
    if (round_en !== 1'b1 && round_idx !== 6'd0) chk("round_idx_idle", 32'(round_idx), 32'd0);
    if (busy !== (load_en | round_en)) chk("busy", 32'(busy), 32'(load_en | round_en));
    if (overrun !== exp_ovr) chk("overrun", 32'(overrun), 32'(exp_ovr));
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask

  // Drive start for one cycle; the bench decides what the core should do with it
  task automatic pulse_start(input bit accepted);
    ev_t e;
    if (accepted) begin
      if (thread_rdy[exp_ptr]) begin
        e.cyc = cyc + 73;
        e.thr = exp_ptr;
        done_q.push_back(e);
      end else begin
        skip_q.push_back(cyc + 1);
      end
      exp_ptr = ~exp_ptr;
    end else begin
      exp_ovr = 1'b1;
    end
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    RESET_N = 1'b0;
    #1;
    chk({tag, "_load_en"}, 32'(load_en), 32'd0);
    chk({tag, "_load_addr"}, 32'(load_addr), 32'd0);
    chk({tag, "_round_en"}, 32'(round_en), 32'd0);
    chk({tag, "_round_idx"}, 32'(round_idx), 32'd0);
    chk({tag, "_cur_thread"}, 32'(cur_thread), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_done_thread"}, 32'(done_thread), 32'd0);
    chk({tag, "_skipped"}, 32'(skipped), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_overrun"}, 32'(overrun), 32'd0);
    done_q.delete();
    skip_q.delete();
    exp_ptr = 1'b0;
    exp_ovr = 1'b0;
    start   = 1'b0;
    step();
    step();
    RESET_N = 1'b1;
    cyc     = 0;
  endtask

  initial begin
    RESET_N    = 1'b1;
    start      = 1'b0;
    thread_rdy = 2'b11;
    #1;

    // Single job: start at 10, load 11..18, rounds 19..82, done at 83
    do_reset("rst0");
    run_to(10);
    pulse_start(1'b1);
    for (int i = 0; i < 8; i++) begin
      chk("j1_load_en", 32'(load_en), 32'd1);
      chk("j1_load_addr", 32'(load_addr), 32'(i));
      chk("j1_cur_thread", 32'(cur_thread), 32'd0);
      step();
    end
    for (int i = 0; i < 64; i++) begin
      chk("j1_round_en", 32'(round_en), 32'd1);
      chk("j1_round_idx", 32'(round_idx), 32'(i));
      step();
    end
    chk("j1_done_cyc83", 32'(done), 32'd1);
    step();
    chk("j1_idle_busy", 32'(busy), 32'd0);

    // Back-to-back jobs, threads 0,1,0, each done overlapping the next load_addr 0
    do_reset("rst1");
    run_to(5);
    pulse_start(1'b1);
    run_to(77);
    chk("b2b_idx63_a", 32'(round_idx), 32'd63);
    pulse_start(1'b1);
    chk("b2b_done_a", 32'(done), 32'd1);
    chk("b2b_load_a", 32'({load_en, load_addr}), 32'h8);
    chk("b2b_thr_a", 32'(cur_thread), 32'd1);
    run_to(149);
    chk("b2b_idx63_b", 32'(round_idx), 32'd63);
    pulse_start(1'b1);
    chk("b2b_done_b", 32'(done), 32'd1);
    chk("b2b_load_b", 32'({load_en, load_addr}), 32'h8);
    chk("b2b_thr_b", 32'(cur_thread), 32'd0);
    run_to(223);
    chk("b2b_overrun", 32'(overrun), 32'd0);

    // Thread 0 not ready: first slot skipped, second runs thread 1
    do_reset("rst2");
    thread_rdy = 2'b10;
    run_to(5);
    pulse_start(1'b1);
    chk("skip_no_load", 32'(load_en), 32'd0);
    chk("skip_not_busy", 32'(busy), 32'd0);
    run_to(77);
    pulse_start(1'b1);
    chk("skip_then_load", 32'(load_en), 32'd1);
    chk("skip_then_thr", 32'(cur_thread), 32'd1);
    run_to(151);
    thread_rdy = 2'b11;

    // Start at round 20 is an overrun; job and pointer unaffected
    do_reset("rst3");
    run_to(5);
    pulse_start(1'b1);
    run_to(34);
    chk("ovr_at_idx20", 32'(round_idx), 32'd20);
    pulse_start(1'b0);
    chk("ovr_set", 32'(overrun), 32'd1);
    chk("ovr_job_continues", 32'(round_idx), 32'd21);
    run_to(80);
    pulse_start(1'b1);
    chk("ovr_next_thr", 32'(cur_thread), 32'd1);
    run_to(154);
    chk("ovr_sticky", 32'(overrun), 32'd1);

    // Reset mid-round: outputs clear at once, no done, first start after release runs thread 0
    do_reset("rst4");
    run_to(5);
    pulse_start(1'b1);
    run_to(44);
    chk("rst_at_idx30", 32'(round_idx), 32'd30);
    do_reset("rst_mid");
    pulse_start(1'b1);
    chk("post_rst_load", 32'(load_en), 32'd1);
    chk("post_rst_thr", 32'(cur_thread), 32'd0);
    run_to(80);

    chk("done_q_empty", 32'(done_q.size()), 32'd0);
    chk("skip_q_empty", 32'(skip_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
